// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the two-master memory bus arbiter.
//  - Bus widths and the default read data returned on a timed-out transaction.
//  - Arbiter state encoding.
//  - Round-robin pick helper used at grant time.
package mem_bus_arbiter_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = 4;

  localparam logic [DATA_W-1:0] DEF_ERR_RDATA = 32'hDEADBEEF;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  // Pick the master to grant: a lone requester always wins; on a tie the
  // master that was not served last wins.
  function automatic logic rr_pick(logic v0, logic v1, logic last);
    if (v0 && v1) begin
      return ~last;
    end
    return v1;
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Native valid/ready memory bus bundle.
//  master modport: drives valid/addr/wdata/wstrb, receives ready/rdata.
//  slave  modport: receives valid/addr/wdata/wstrb, drives ready/rdata.
//  wstrb == 0 denotes a read; rdata is only meaningful while ready is high.
interface mem_bus_arbiter_if;
  import mem_bus_arbiter_pkg::*;

  logic              valid;
  logic              ready;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [STRB_W-1:0] wstrb;
  logic [DATA_W-1:0] rdata;

  modport master (
    output valid, addr, wdata, wstrb,
    input  ready, rdata
  );

  modport slave (
    input  valid, addr, wdata, wstrb,
    output ready, rdata
  );
endinterface

// File: rtl/mem_bus_arbiter_watchdog.sv
// Bus watchdog: counts cycles while enabled and flags expiry.
//  clk       in  clock, rising edge
//  rst       in  asynchronous active-low reset
//  clear_i   in  force count to 0 (has priority over enable_i)
//  enable_i  in  advance the count by one this cycle
//  expire_o  out count has reached TIMEOUT-1
// The count saturates at TIMEOUT-1 so it can never wrap back to zero.
module mem_bus_arbiter_watchdog #(
  parameter int TIMEOUT = 256,
  parameter int TO_W    = 9
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic enable_i,
  output logic expire_o
);

  localparam logic [TO_W-1:0] LAST = TO_W'(TIMEOUT - 1);

  logic [TO_W-1:0] cnt_q;
  logic [TO_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i && (cnt_q != LAST)) begin
      cnt_d = cnt_q + TO_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = (cnt_q == LAST);

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-master round-robin arbiter for the native valid/ready memory bus.
//  clk      in   clock, rising edge
//  rst      in   asynchronous active-low reset
//  m0       bus  master 0 (CPU) side
//  m1       bus  master 1 (DMA/debug) side
//  s        bus  towards address decoder / slaves
//  bus_err  out  1-cycle pulse when a transaction is terminated by timeout
//  busy     out  a granted transaction is in progress
// One transaction in flight; a grant cycle in IDLE precedes every BUSY phase.
// A slave that does not answer within TIMEOUT BUSY cycles is cut off and the
// master receives ERR_RDATA together with a bus_err pulse.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int                TIMEOUT   = 256,
  parameter int                TO_W      = 9,
  parameter logic [DATA_W-1:0] ERR_RDATA = DEF_ERR_RDATA
) (
  input  logic                clk,
  input  logic                rst,
  mem_bus_arbiter_if.slave    m0,
  mem_bus_arbiter_if.slave    m1,
  mem_bus_arbiter_if.master   s,
  output logic                bus_err,
  output logic                busy
);

  state_e state_q, state_d;
  logic   gnt_q, gnt_d;
  logic   last_q, last_d;

  logic              wd_clear;
  logic              wd_en;
  logic              wd_expire;
  logic              sel_valid;
  logic              done;
  logic [DATA_W-1:0] ret_rdata;

  mem_bus_arbiter_watchdog #(
    .TIMEOUT (TIMEOUT),
    .TO_W    (TO_W)
  ) u_watchdog (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (wd_clear),
    .enable_i (wd_en),
    .expire_o (wd_expire)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      gnt_q   <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    last_d    = last_q;
    wd_clear  = 1'b0;
    wd_en     = 1'b0;
    done      = 1'b0;
    ret_rdata = '0;
    bus_err   = 1'b0;
    s.valid   = 1'b0;
    s.addr    = '0;
    s.wdata   = '0;
    s.wstrb   = '0;
    sel_valid = gnt_q ? m1.valid : m0.valid;

    unique case (state_q)
      ST_IDLE: begin
        // Counter is held at zero so every BUSY phase starts fresh.
        wd_clear = 1'b1;
        if (m0.valid || m1.valid) begin
          gnt_d   = rr_pick(m0.valid, m1.valid, last_q);
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        s.valid = sel_valid;
        s.addr  = gnt_q ? m1.addr  : m0.addr;
        s.wdata = gnt_q ? m1.wdata : m0.wdata;
        s.wstrb = gnt_q ? m1.wstrb : m0.wstrb;
        if (!sel_valid) begin
          // Master withdrew its request: abandon silently, fairness untouched.
          state_d = ST_IDLE;
        end else if (s.ready) begin
          // A slave answer on the expiry cycle still counts as a normal completion.
          done      = 1'b1;
          ret_rdata = s.rdata;
        end else if (wd_expire) begin
          done      = 1'b1;
          ret_rdata = ERR_RDATA;
          bus_err   = 1'b1;
        end else begin
          wd_en = 1'b1;
        end
        if (done) begin
          last_d  = gnt_q;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    m0.ready = done & ~gnt_q;
    m1.ready = done &  gnt_q;
    m0.rdata = (done & ~gnt_q) ? ret_rdata : '0;
    m1.rdata = (done &  gnt_q) ? ret_rdata : '0;
  end

  assign busy = (state_q == ST_BUSY);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed scenarios with literal
// expectations, then randomized traffic, all cross-checked every cycle
// against a transaction-level model of the arbitration rules.
module tb_mem_bus_arbiter;
  import mem_bus_arbiter_pkg::*;

  localparam int          TIMEOUT = 8;
  localparam int          TO_W    = 4;
  localparam logic [31:0] ERR_RD  = 32'hDEADBEEF;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic bus_err;
  logic busy;

  mem_bus_arbiter_if m0_bus ();
  mem_bus_arbiter_if m1_bus ();
  mem_bus_arbiter_if s_bus ();

  mem_bus_arbiter #(
    .TIMEOUT   (TIMEOUT),
    .TO_W      (TO_W),
    .ERR_RDATA (ERR_RD)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .m0      (m0_bus),
    .m1      (m1_bus),
    .s       (s_bus),
    .bus_err (bus_err),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  // owner: master currently holding the bus (-1 = nobody, arbitration pending)
  // waited: BUSY cycles the owner has already spent without an answer
  // served_last: master that most recently completed a transaction
  int owner_q = -1, waited_q = 0, served_last_q = 1;
  int owner_n = -1, waited_n = 0, served_last_n = 1;

  logic        v [2];
  logic [31:0] a [2];
  logic [31:0] w [2];
  logic [3:0]  sb[2];
  bit          e_rdy[2];
  logic [31:0] e_rd [2];
  logic        e_sv, e_err;
  logic [31:0] e_addr, e_wd;
  logic [3:0]  e_st;

  always @(negedge clk) begin
    if (rst) begin
      v[0] = m0_bus.valid; a[0] = m0_bus.addr; w[0] = m0_bus.wdata; sb[0] = m0_bus.wstrb;
      v[1] = m1_bus.valid; a[1] = m1_bus.addr; w[1] = m1_bus.wdata; sb[1] = m1_bus.wstrb;
      e_sv = 1'b0; e_err = 1'b0; e_addr = '0; e_wd = '0; e_st = '0;
      e_rdy[0] = 1'b0; e_rdy[1] = 1'b0; e_rd[0] = '0; e_rd[1] = '0;
      owner_n = owner_q; waited_n = waited_q; served_last_n = served_last_q;
      if (owner_q < 0) begin
        if (v[0] && v[1]) begin
          owner_n = 1 - served_last_q;
          waited_n = 0;
        end else if (v[0] || v[1]) begin
          owner_n = v[1] ? 1 : 0;
          waited_n = 0;
        end
      end else begin
        e_addr = a[owner_q]; e_wd = w[owner_q]; e_st = sb[owner_q]; e_sv = v[owner_q];
        if (!v[owner_q]) begin
          owner_n = -1;
        end else if (s_bus.ready) begin
          e_rdy[owner_q] = 1'b1; e_rd[owner_q] = s_bus.rdata;
          served_last_n = owner_q; owner_n = -1;
        end else if (waited_q >= TIMEOUT - 1) begin
          e_rdy[owner_q] = 1'b1; e_rd[owner_q] = ERR_RD; e_err = 1'b1;
          served_last_n = owner_q; owner_n = -1;
        end else begin
          waited_n = waited_q + 1;
        end
      end
      chk("busy",     busy,          owner_q >= 0);
      chk("s_valid",  s_bus.valid,   e_sv);
      chk("s_addr",   s_bus.addr,    e_addr);
      chk("s_wdata",  s_bus.wdata,   e_wd);
      chk("s_wstrb",  s_bus.wstrb,   e_st);
      chk("bus_err",  bus_err,       e_err);
      chk("m0_ready", m0_bus.ready,  e_rdy[0]);
      chk("m0_rdata", m0_bus.rdata,  e_rd[0]);
      chk("m1_ready", m1_bus.ready,  e_rdy[1]);
      chk("m1_rdata", m1_bus.rdata,  e_rd[1]);
      for (int i = 0; i < 2; i++) begin
        if (e_rdy[i])
          $display("txn m%0d addr=%08h wstrb=%h rdata=%08h err=%0d t=%0t",
                   i, a[i], sb[i], e_rd[i], e_err, $time);
      end
    end
  end

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner_q <= -1; waited_q <= 0; served_last_q <= 1;
    end else begin
      owner_q <= owner_n; waited_q <= waited_n; served_last_q <= served_last_n;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_m(int i, logic vld, logic [31:0] ad, logic [31:0] wd, logic [3:0] st);
    if (i == 0) begin
      m0_bus.valid = vld; m0_bus.addr = ad; m0_bus.wdata = wd; m0_bus.wstrb = st;
    end else begin
      m1_bus.valid = vld; m1_bus.addr = ad; m1_bus.wdata = wd; m1_bus.wstrb = st;
    end
  endtask

  task automatic clear_inputs();
    set_m(0, 1'b0, '0, '0, '0);
    set_m(1, 1'b0, '0, '0, '0);
    s_bus.ready = 1'b0;
    s_bus.rdata = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  int  order[$];
  int  rc, errs, err_c, first;
  logic [31:0] rd;
  logic        sv_at;
  bit  act[2];
  bit  dead;

  initial begin
    do_reset();
    @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_s_valid", s_bus.valid, 0);
    tick();

    // 1: m0 read, slave answers on the 4th cycle after the request
    set_m(0, 1'b1, 32'h0000_0010, 32'h0, 4'h0);
    s_bus.rdata = 32'h1234_5678;
    for (int c = 0; c <= 4; c++) begin
      s_bus.ready = (c == 4);
      @(negedge clk);
      chk("t1_m0_ready", m0_bus.ready, c == 4);
      chk("t1_m1_ready", m1_bus.ready, 0);
      chk("t1_bus_err", bus_err, 0);
      if (c == 4) chk("t1_m0_rdata", m0_bus.rdata, 32'h1234_5678);
      tick();
    end
    clear_inputs();

    // 2: simultaneous requests from reset alternate m0,m1,m0,m1
    do_reset();
    set_m(0, 1'b1, 32'h100, 32'h1, 4'hF);
    set_m(1, 1'b1, 32'h200, 32'h2, 4'h3);
    s_bus.ready = 1'b1; s_bus.rdata = 32'h5555_AAAA;
    for (int c = 0; c < 40 && order.size() < 4; c++) begin
      @(negedge clk);
      if (m0_bus.ready) order.push_back(0);
      if (m1_bus.ready) order.push_back(1);
      tick();
    end
    chk("t2_count", order.size(), 4);
    for (int i = 0; i < 4; i++)
      chk("t2_order", (i < order.size()) ? order[i] : 99, i % 2);
    clear_inputs();
    tick();

    // 3: m1 write to a dead slave times out after 8 BUSY cycles
    set_m(1, 1'b1, 32'h0200_0000, 32'hA5, 4'b0001);
    rc = -1; errs = 0; err_c = -1; rd = '0; sv_at = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (m1_bus.ready && rc < 0) begin
        rc = c; rd = m1_bus.rdata; sv_at = s_bus.valid;
      end
      if (bus_err) begin
        errs++; err_c = c;
      end
      tick();
      if (rc >= 0) m1_bus.valid = 1'b0;
    end
    chk("t3_ready_cycle", rc, 8);
    chk("t3_rdata", rd, 32'hDEADBEEF);
    chk("t3_err_pulses", errs, 1);
    chk("t3_err_cycle", err_c, 8);
    chk("t3_s_valid_at_to", sv_at, 1);
    set_m(0, 1'b1, 32'h44, 32'h0, 4'h0);
    s_bus.ready = 1'b1; s_bus.rdata = 32'h0BAD_F00D;
    for (int c = 0; c <= 1; c++) begin
      @(negedge clk);
      chk("t3_next_ready", m0_bus.ready, c == 1);
      chk("t3_next_err", bus_err, 0);
      tick();
    end
    clear_inputs();
    tick();

    // 4: slave answer coincides with the expiry cycle -> normal completion
    set_m(0, 1'b1, 32'h80, 32'h0, 4'h0);
    s_bus.rdata = 32'hCAFE_F00D;
    for (int c = 0; c <= 8; c++) begin
      s_bus.ready = (c == 8);
      @(negedge clk);
      chk("t4_m0_ready", m0_bus.ready, c == 8);
      chk("t4_bus_err", bus_err, 0);
      if (c == 8) chk("t4_m0_rdata", m0_bus.rdata, 32'hCAFE_F00D);
      tick();
    end
    clear_inputs();
    tick();

    // 5: asynchronous reset mid-BUSY clears outputs at once; m0 wins the tie afterwards
    set_m(0, 1'b1, 32'h40, 32'h77, 4'hF);
    tick(); tick();
    chk("t5_busy_before", busy, 1);
    #2 rst = 1'b0;
    #1;
    chk("t5_busy", busy, 0);
    chk("t5_s_valid", s_bus.valid, 0);
    chk("t5_s_addr", s_bus.addr, 0);
    chk("t5_s_wstrb", s_bus.wstrb, 0);
    chk("t5_m0_ready", m0_bus.ready, 0);
    chk("t5_bus_err", bus_err, 0);
    @(posedge clk);
    #1 rst = 1'b1;
    set_m(1, 1'b1, 32'h48, 32'h0, 4'h0);
    s_bus.ready = 1'b1;
    first = -1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (first < 0 && m0_bus.ready) first = 0;
      if (first < 0 && m1_bus.ready) first = 1;
      tick();
    end
    chk("t5_first_after_rst", first, 0);
    clear_inputs();
    tick();

    // 6: m0 abandons mid-BUSY; pending m1 is granted next
    set_m(0, 1'b1, 32'h90, 32'h0, 4'h0);
    for (int c = 0; c <= 4; c++) begin
      if (c == 1) set_m(1, 1'b1, 32'hA0, 32'h0, 4'h0);
      if (c == 2) m0_bus.valid = 1'b0;
      s_bus.ready = (c == 4);
      @(negedge clk);
      if (c == 2) begin
        chk("t6_busy_drop", busy, 1);
        chk("t6_m0_ready", m0_bus.ready, 0);
        chk("t6_bus_err", bus_err, 0);
      end
      if (c == 3) chk("t6_idle", busy, 0);
      if (c == 4) chk("t6_m1_ready", m1_bus.ready, 1);
      tick();
    end
    clear_inputs();
    tick();

    // Randomized traffic with alternating healthy / dead slave phases
    act[0] = 1'b0; act[1] = 1'b0; dead = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (c % 400 == 0) dead = ($urandom_range(0, 1) == 1);
      for (int i = 0; i < 2; i++) begin
        if (act[i] && e_rdy[i]) act[i] = 1'b0;
        else if (act[i] && $urandom_range(0, 99) == 0) act[i] = 1'b0;
        if (!act[i] && $urandom_range(0, 99) < 40) begin
          act[i] = 1'b1;
          set_m(i, 1'b1, $urandom, $urandom, 4'($urandom_range(0, 15)));
        end
        if (i == 0) m0_bus.valid = act[i]; else m1_bus.valid = act[i];
      end
      s_bus.ready = dead ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 99) < 50);
      s_bus.rdata = $urandom;
      tick();
    end
    clear_inputs();
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
